// File: rtl/alu16_seq_if.sv
// -----------------------------------------------------------------------------
// alu16_seq_if -- host-side request/response bundle for alu16_seq.
//
// Signals (W = 4*NIBBLES):
//   start        request, sampled by the sequencer only while idle
//   op_m[1:0]    ALU mode, forwarded to the slice unchanged
//   op_ai, op_bi operand-modifier controls, forwarded unchanged
//   op_a, op_b   W-bit operands
//   cin          carry into the least-significant nibble
//   busy         high while nibbles are being issued
//   done         one-cycle pulse, result/cout valid
//   result       registered W-bit result
//   cout         final slice carry
//   zero         result-is-zero flag (only with ALU16_SEQ_ZFLAG_EN defined)
//
// Modports: master = requester side, slave = alu16_seq side.
// Configuration macro: ALU16_SEQ_ZFLAG_EN adds the zero flag.
// -----------------------------------------------------------------------------
interface alu16_seq_if #(
    parameter int NIBBLES = 4
) ();
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic [1:0]   op_m;
    logic         op_ai;
    logic         op_bi;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         cin;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         cout;
`ifdef ALU16_SEQ_ZFLAG_EN
    logic         zero;

    modport master (
        output start, op_m, op_ai, op_bi, op_a, op_b, cin,
        input  busy, done, result, cout, zero
    );

    modport slave (
        input  start, op_m, op_ai, op_bi, op_a, op_b, cin,
        output busy, done, result, cout, zero
    );
`else
    modport master (
        output start, op_m, op_ai, op_bi, op_a, op_b, cin,
        input  busy, done, result, cout
    );

    modport slave (
        input  start, op_m, op_ai, op_bi, op_a, op_b, cin,
        output busy, done, result, cout
    );
`endif
endinterface

// File: rtl/alu16_seq.sv
// -----------------------------------------------------------------------------
// alu16_seq -- sequences a W-bit ALU operation (W = 4*NIBBLES) through an
// external combinational 4-bit ALU slice, one nibble per clock, LSB first.
// The slice's carry out of nibble k becomes its carry in for nibble k+1.
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   bus (slave)       request/response bundle (see alu16_seq_if)
//   alu_m, alu_ai,    latched controls driven to the slice
//   alu_bi
//   alu_a, alu_b      current operand nibbles (0 outside RUN)
//   alu_kin           current carry into the slice (0 outside RUN)
//   alu_out, alu_kout combinational result/carry returned by the slice
//
// Configuration macro: ALU16_SEQ_ZFLAG_EN -- when defined, bus.zero is
// registered with the result and is 1 iff the full W-bit result is 0.
// -----------------------------------------------------------------------------
module alu16_seq #(
    parameter int NIBBLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    alu16_seq_if.slave       bus,
    output logic [1:0]       alu_m,
    output logic             alu_ai,
    output logic             alu_bi,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_kin,
    input  logic [3:0]       alu_out,
    input  logic             alu_kout
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q;
    logic [IW-1:0] idx_q;
    logic          carry_q;
    logic [W-1:0]  a_q;
    logic [W-1:0]  b_q;
    logic [1:0]    m_q;
    logic          ai_q;
    logic          bi_q;
    logic [W-1:0]  acc_q;
    logic [W-1:0]  acc_next;

    // Accumulator with the slice's current nibble merged in; on the final
    // RUN edge this is the complete result.
    always_comb begin
        // NOTE: default first so every path assigns acc_next -- no latch.
        acc_next = acc_q;
        acc_next[{idx_q, 2'b00} +: 4] = alu_out;
    end

    assign alu_m   = m_q;
    assign alu_ai  = ai_q;
    assign alu_bi  = bi_q;
    assign alu_a   = (state_q == RUN) ? a_q[{idx_q, 2'b00} +: 4] : 4'd0;
    assign alu_b   = (state_q == RUN) ? b_q[{idx_q, 2'b00} +: 4] : 4'd0;
    assign alu_kin = (state_q == RUN) ? carry_q : 1'b0;

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            carry_q    <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            m_q        <= '0;
            ai_q       <= 1'b0;
            bi_q       <= 1'b0;
            acc_q      <= '0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.result <= '0;
            bus.cout   <= 1'b0;
`ifdef ALU16_SEQ_ZFLAG_EN
            bus.zero   <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        a_q      <= bus.op_a;
                        b_q      <= bus.op_b;
                        m_q      <= bus.op_m;
                        ai_q     <= bus.op_ai;
                        bi_q     <= bus.op_bi;
                        carry_q  <= bus.cin;
                        idx_q    <= '0;
                        state_q  <= RUN;
                        bus.busy <= 1'b1;
                    end
                end
                RUN: begin
                    acc_q   <= acc_next;
                    carry_q <= alu_kout;
                    idx_q   <= idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        bus.result <= acc_next;
                        bus.cout   <= alu_kout;
`ifdef ALU16_SEQ_ZFLAG_EN
                        bus.zero   <= (acc_next == '0);
`endif
                        state_q    <= DONE;
                        bus.busy   <= 1'b0;
                        bus.done   <= 1'b1;
                    end
                end
                DONE: begin
                    // Any start seen here is dropped, not queued.
                    state_q  <= IDLE;
                    bus.done <= 1'b0;
                end
                default: begin
                    state_q  <= IDLE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu16_seq.sv
// -----------------------------------------------------------------------------
// tb_alu16_seq -- self-checking bench for alu16_seq (NIBBLES = 4).
// The 4-bit slice is modelled as a plain adder: {kout,out} = a + b + kin.
// Expected values come from whole-word arithmetic on the operands.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_alu16_seq;
    localparam int NIB = 4;

    logic       clk;
    logic       rst_n;
    logic [1:0] alu_m;
    logic       alu_ai;
    logic       alu_bi;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic       alu_kin;
    logic [3:0] alu_out;
    logic       alu_kout;

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    alu16_seq_if #(.NIBBLES(NIB)) bus ();

    alu16_seq #(.NIBBLES(NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_m    (alu_m),
        .alu_ai   (alu_ai),
        .alu_bi   (alu_bi),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_kin  (alu_kin),
        .alu_out  (alu_out),
        .alu_kout (alu_kout)
    );

    // Slice model
    assign {alu_kout, alu_out} = {1'b0, alu_a} + {1'b0, alu_b} + {4'd0, alu_kin};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Issues one operation starting at the current falling edge and checks the
    // issued nibbles, carries, timing and final result. With interfere set, a
    // second start and new operands are driven mid-operation.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c,
                         input logic [1:0] m, input logic ai, input logic bi,
                         input bit interfere);
        int unsigned sum;
        int unsigned low_a;
        int unsigned low_b;
        int unsigned mask;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.cin   = c;
        bus.op_m  = m;
        bus.op_ai = ai;
        bus.op_bi = bi;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        sum = int'(a) + int'(b) + int'(c);
        for (int k = 0; k < NIB; k++) begin
            mask  = (32'd1 << (4 * k)) - 1;
            low_a = int'(a) & mask;
            low_b = int'(b) & mask;
            check("busy_run", {31'd0, bus.busy}, 32'd1);
            check("done_run", {31'd0, bus.done}, 32'd0);
            check("alu_a", {28'd0, alu_a}, (int'(a) >> (4 * k)) & 32'hF);
            check("alu_b", {28'd0, alu_b}, (int'(b) >> (4 * k)) & 32'hF);
            check("alu_kin", {31'd0, alu_kin}, ((low_a + low_b + int'(c)) >> (4 * k)) & 32'h1);
            check("alu_ctl", {29'd0, alu_m, alu_ai, alu_bi}, {29'd0, m, ai, bi});
            if (interfere && k == 1) begin
                bus.start = 1'b1;
                bus.op_a  = 16'h2222;
                bus.op_b  = 16'h2222;
                bus.cin   = 1'b1;
                bus.op_m  = ~m;
            end
            if (interfere && k == 2) bus.start = 1'b0;
            @(negedge clk);
        end
        check("done_pulse", {31'd0, bus.done}, 32'd1);
        check("busy_done", {31'd0, bus.busy}, 32'd0);
        check("result", {16'd0, bus.result}, sum & 32'hFFFF);
        check("cout", {31'd0, bus.cout}, (sum >> 16) & 32'h1);
`ifdef ALU16_SEQ_ZFLAG_EN
        check("zero", {31'd0, bus.zero}, ((sum & 32'hFFFF) == 0) ? 32'd1 : 32'd0);
`endif
        check("alu_a_idle", {28'd0, alu_a}, 32'd0);
        @(negedge clk);
        check("done_one_cycle", {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int done_cnt;
        int done_pos[$];
        logic [15:0] ra;
        logic [15:0] rb;

        // Reset held for 3 cycles
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.op_a  = 16'hA5A5;
        bus.op_b  = 16'h5A5A;
        bus.cin   = 1'b1;
        bus.op_m  = 2'b11;
        bus.op_ai = 1'b1;
        bus.op_bi = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_result", {16'd0, bus.result}, 32'h0000);
        check("rst_cout", {31'd0, bus.cout}, 32'd0);
        check("rst_alu", {20'd0, alu_a, alu_b, alu_kin, alu_m, alu_ai, alu_bi}, 32'd0);

        // First start at the first rising edge with rst_n high
        rst_n = 1'b1;
        do_op(16'h1234, 16'h1111, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0);

        // Carry ripples through every nibble
        do_op(16'hFFFF, 16'h0001, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        // Start during busy is ignored; operand changes mid-run have no effect
        do_op(16'h1000, 16'h0001, 1'b0, 2'b10, 1'b1, 1'b0, 1'b1);
        done_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus.done === 1'b1) done_cnt++;
            @(negedge clk);
        end
        check("ignored_start_no_done", done_cnt, 0);
        check("ignored_start_result", {16'd0, bus.result}, 32'h1001);

        // Reset mid-run aborts the operation
        bus.op_a  = 16'h00FF;
        bus.op_b  = 16'h0001;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", {31'd0, bus.busy}, 32'd0);
        check("abort_done", {31'd0, bus.done}, 32'd0);
        check("abort_result", {16'd0, bus.result}, 32'h0000);
        check("abort_alu", {23'd0, alu_a, alu_b, alu_kin}, 32'd0);
        done_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) done_cnt++;
        end
        check("abort_no_done", done_cnt, 0);
        check("abort_result_held", {16'd0, bus.result}, 32'h0000);
        rst_n = 1'b1;
        do_op(16'h0002, 16'h0003, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);

        // start held high for 12 cycles: one operation every 6 cycles
        bus.op_a  = 16'h0001;
        bus.op_b  = 16'h0001;
        bus.cin   = 1'b0;
        bus.start = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (bus.done === 1'b1) begin
                done_pos.push_back(i);
                check("held_result", {16'd0, bus.result}, 32'h0002);
            end
        end
        bus.start = 1'b0;
        check("held_done_count", done_pos.size(), 2);
        if (done_pos.size() == 2) begin
            check("held_first_done", done_pos[0], 5);
            check("held_period", done_pos[1] - done_pos[0], 6);
        end
        repeat (8) begin
            @(negedge clk);
            check("held_no_extra", {31'd0, bus.done}, 32'd0);
        end

        // Randomized operations against the whole-word model
        for (int t = 0; t < 24; t++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (t % 6 == 0) rb = 16'(16'h0000 - ra);
            do_op(ra, rb, 1'($urandom), 2'($urandom), 1'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
